// File: rtl/retry_arbiter.sv
// Round-robin retry scheduler with per-ID retry budget and pending-retry FIFO.
// Optional parity check on request IDs: define RETRY_ARBITER_PARITY_CHECK_EN.
module retry_arbiter #(
    parameter int NumReq     = 2,
    parameter int IDSize     = 4,
    parameter int MaxRetries = 3,
    parameter int FifoDepth  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq*IDSize-1:0] req_id_i,
    input  logic [NumReq-1:0]        req_valid_i,
    output logic [NumReq-1:0]        req_ready_o,
    output logic [IDSize-1:0]        retry_id_o,
    output logic                     retry_valid_o,
    input  logic                     retry_ready_i,
    input  logic [IDSize-1:0]        done_id_i,
    input  logic                     done_valid_i,
    output logic [IDSize-1:0]        abort_id_o,
    output logic                     abort_valid_o,
    output logic                     parity_err_o
);
    localparam int IdxW = IDSize - 1;
    localparam int NIdx = 1 << IdxW;
    localparam int CntW = $clog2(MaxRetries + 1);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int RrW  = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [RrW-1:0]    r_rr;
    logic [CntW-1:0]   r_cnt [NIdx];
    logic [IDSize-1:0] r_mem [FifoDepth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [PtrW:0]     r_count;
    logic              r_abort_v;
    logic [IDSize-1:0] r_abort_id;
    logic              r_par_err;

    logic              w_found;
    logic [RrW-1:0]    w_win;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic [IDSize-1:0] w_id;
    logic [IdxW-1:0]   w_idx;
    logic [IdxW-1:0]   w_done_idx;
    logic [CntW-1:0]   w_cnt_cur;
    logic              w_at_max;
    logic              w_par_ok;
    logic              w_push;
    logic              w_abort;
    logic              w_pop;
    logic [PtrW-1:0]   w_wptr_nxt;
    logic [PtrW-1:0]   w_rptr_nxt;
    logic              w_unused_done;

    // Cyclic search for the first valid requester starting at r_rr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!w_found && req_valid_i[(int'(r_rr) + k) % NumReq]) begin
                w_found = 1'b1;
                w_win   = RrW'((int'(r_rr) + k) % NumReq);
            end
        end
    end

    assign w_full   = (r_count == (PtrW+1)'(FifoDepth));
    assign w_empty  = (r_count == '0);
    assign w_accept = w_found & ~w_full;

    always_comb begin
        req_ready_o = '0;
        if (w_accept) req_ready_o[w_win] = 1'b1;
    end

    assign w_id          = req_id_i[int'(w_win)*IDSize +: IDSize];
    assign w_idx         = w_id[IdxW-1:0];
    assign w_done_idx    = done_id_i[IdxW-1:0];
    assign w_unused_done = done_id_i[IDSize-1];

    // A same-cycle completion clears the budget before the request is judged.
    assign w_cnt_cur = (done_valid_i && (w_done_idx == w_idx)) ? '0 : r_cnt[w_idx];
    assign w_at_max  = (w_cnt_cur == CntW'(MaxRetries));

`ifdef RETRY_ARBITER_PARITY_CHECK_EN
    assign w_par_ok = (w_id[IDSize-1] == ^w_id[IDSize-2:0]);
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_push  = w_accept & w_par_ok & ~w_at_max;
    assign w_abort = w_accept & w_par_ok & w_at_max;
    assign w_pop   = ~w_empty & retry_ready_i;

    assign w_wptr_nxt = (r_wptr == PtrW'(FifoDepth-1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PtrW'(FifoDepth-1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NIdx; i++) r_cnt[i] <= '0;
        end else begin
            if (done_valid_i) r_cnt[w_done_idx] <= '0;
            if (w_abort) r_cnt[w_idx] <= '0;
            else if (w_push) r_cnt[w_idx] <= w_cnt_cur + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_id;
                r_wptr        <= w_wptr_nxt;
            end
            if (w_pop) r_rptr <= w_rptr_nxt;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_abort_v  <= 1'b0;
            r_abort_id <= '0;
            r_par_err  <= 1'b0;
        end else begin
            if (w_accept)
                r_rr <= (w_win == RrW'(NumReq-1)) ? '0 : w_win + 1'b1;
            r_abort_v <= w_abort;
            if (w_abort) r_abort_id <= w_id;
            r_par_err <= w_accept & ~w_par_ok;
        end
    end

    assign retry_valid_o = ~w_empty;
    assign retry_id_o    = r_mem[r_rptr];
    assign abort_valid_o = r_abort_v;
    assign abort_id_o    = r_abort_id;
`ifdef RETRY_ARBITER_PARITY_CHECK_EN
    assign parity_err_o  = r_par_err;
`else
    assign parity_err_o  = 1'b0;
`endif

endmodule

// File: doc/retry_arbiter.md
# retry_arbiter

Retry scheduler sitting between the error checkers (voters / ECC checkers) at the end of a time-redundant pipeline and the retry input of the retry-issue stage. It accepts failed-transaction IDs from several checkers, arbitrates round-robin, enforces a per-ID retry budget, and queues the surviving IDs into a single retry stream. IDs that exhaust their budget are reported as aborts instead of being retried.

## Interface
- `NumReq`, default 2: number of checker request ports, ≥ 1.
- `IDSize`, default 4: ID width including the MSB parity bit. The index is `id[IDSize-2:0]`, giving 2^(IDSize-1) indices.
- `MaxRetries`, default 3: number of retries allowed per ID before it is aborted, ≥ 1.
- `FifoDepth`, default 4: depth of the pending-retry queue, a power of 2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `req_id_i` in NumReq×IDSize: failed ID from each checker.
- `req_valid_i` in NumReq: request valid per checker.
- `req_ready_o` out NumReq: request accepted per checker.
- `retry_id_o` out IDSize: ID to re-issue.
- `retry_valid_o` out 1: retry pending.
- `retry_ready_i` in 1: retry consumer ready.
- `done_id_i` in IDSize: ID that completed without error.
- `done_valid_i` in 1: completion strobe. Always accepted; there is no ready.
- `abort_id_o` out IDSize: ID dropped for exhausting its budget.
- `abort_valid_o` out 1: one-cycle abort pulse.
- `parity_err_o` out 1: one-cycle pulse when a request ID fails its parity check.

## Operation
- **Round-robin pointer.** `rr_q` is in [0, NumReq-1].
  - Winner = first requester i with `req_valid_i[i]`, searching cyclically from `rr_q`.
  - `req_ready_o[winner] = ~full`. All other ready bits are 0.
  - At most one request is accepted per cycle.
  - On an accepted handshake, `rr_q <= (winner+1) mod NumReq`. Otherwise `rr_q` holds.
- **Per-index retry counter.** One counter per index, `cnt[idx]`, width `$clog2(MaxRetries+1)`.
- **Processing an accepted request**, in priority order:
  1. Parity check (see Configuration). On failure: drop the ID, pulse `parity_err_o`, leave counters unchanged.
  2. If `cnt[idx] == MaxRetries`: drop the ID, pulse `abort_valid_o` with `abort_id_o = id`, and set `cnt[idx] <= 0`.
  3. Otherwise: `cnt[idx] <= cnt[idx]+1` and push the ID into the FIFO.
  - Dropped requests still complete their handshake. Ready is never gated by parity or by the counter.
- **Completion.** `done_valid_i` sets `cnt[done_idx] <= 0`. The done ID is not parity-checked.
- **Done and request on the same index in the same cycle.** Done is applied first, so the request sees a count of 0: it is pushed and the counter becomes 1.
- **FIFO.**
  - `retry_valid_o = ~empty`; `retry_id_o` = head entry, held stable while not popped.
  - Pop on `retry_valid_o & retry_ready_i`.
  - `full` is the registered fill state. There is no same-cycle bypass: a push into a full FIFO is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged. Pointers wrap modulo FifoDepth.

## Timing
- **Reset values.**
  - `retry_valid_o=0`, `retry_id_o=0`, `abort_valid_o=0`, `abort_id_o=0`, `parity_err_o=0`.
  - `req_ready_o` = one-hot on the valid requester nearest port 0 (FIFO empty).
  - All counters 0, `rr_q=0`, FIFO empty.
- **Reset mid-operation.** Queued retries and counters are discarded in the cycle `rst_i` is sampled high.
- **Latency.** Request accepted at edge N → `retry_valid_o` asserted after edge N (one cycle) when the FIFO was empty.
- **Pulses.** `abort_valid_o` and `parity_err_o` are registered and assert for exactly the cycle after the accepting edge.
- **Combinational path.** `req_ready_o` depends only on `req_valid_i`, `rr_q` and `full`. There is no path from `retry_ready_i`.
- **Output stability.** `retry_valid_o` and `retry_id_o` are driven from registers and do not drop without a pop.

## Configuration
- **`RETRY_ARBITER_PARITY_CHECK_EN` defined:** a request is valid only if `id[IDSize-1] == ^id[IDSize-2:0]`. Invalid IDs are dropped with a `parity_err_o` pulse.
- **Not defined:** no parity check; all IDs proceed to the budget check; `parity_err_o` is tied to 0.

## Test plan
- **Single retry.** After reset, port 0 sends `4'b0011` (parity OK), `retry_ready_i=1` → `retry_valid_o` high for 1 cycle with `retry_id_o=4'b0011`; `cnt[3]=1`.
- **Round-robin.** Ports 0 and 1 valid continuously with `4'b1001` / `4'b0011`, FIFO draining → grants alternate 0,1,0,1; none lost.
- **Budget exhaustion.** `4'b0011` requested 4 times with no done (MaxRetries=3) → first 3 pushed; the 4th produces an `abort_valid_o` pulse with `abort_id_o=4'b0011`, no push, and `cnt[3]` returns to 0.
- **Done resets the budget.** 3 retries of `4'b1001`, then `done_valid_i` with `4'b1001`, then a 4th request → pushed, not aborted.
  - Also: done and request for `4'b1001` in the same cycle → pushed, `cnt[1]=1`.
- **Full FIFO.** `retry_ready_i=0`, 4 pushes → `req_ready_o=0`. Assert `retry_ready_i` → head `ID#1` pops, ready returns the next cycle, order preserved.
- **Parity error (macro on).** Request `4'b1011` → `parity_err_o` pulses once, FIFO unchanged, `cnt[3]` unchanged. With the macro off → the same request is pushed.
